// File: rtl/switch_pulse_gen.sv
// Switch front end: per-channel 2-flop synchroniser, debounce filter, edge
// detect and pulse stretcher feeding the lamp controller's S inputs.
module switch_pulse_gen #(
  parameter int unsigned N_SW         = 3,
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter int unsigned PULSE_LEN    = 1,
  parameter bit          REL_PULSE    = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_level,
  output logic [N_SW-1:0] sw_pulse,
  output logic            any_pulse
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned StW  = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYC - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [StW-1:0]  StLoad  = StW'(PULSE_LEN - 1);
  localparam logic [StW-1:0]  StOne   = StW'(1);

  logic [N_SW-1:0] sync1_q, sync1_d;
  logic [N_SW-1:0] sync2_q, sync2_d;
  logic [N_SW-1:0] level_q, level_d;
  logic [N_SW-1:0] pulse_q, pulse_d;
  logic            any_q, any_d;
  logic [CntW-1:0] cnt_q [N_SW];
  logic [CntW-1:0] cnt_d [N_SW];
  logic [StW-1:0]  st_q  [N_SW];
  logic [StW-1:0]  st_d  [N_SW];
  logic [N_SW-1:0] accept;
  logic [N_SW-1:0] fire;

  // Next-state: synchroniser shift, debounce count/accept, pulse load/stretch.
  always_comb begin
    sync1_d = sw_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    pulse_d = pulse_q;
    cnt_d   = cnt_q;
    st_d    = st_q;
    accept  = '0;
    fire    = '0;
    for (int unsigned i = 0; i < N_SW; i++) begin
      // Any return to the accepted level discards progress.
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntLast) begin
        level_d[i] = sync2_q[i];
        cnt_d[i]   = '0;
        accept[i]  = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CntOne;
      end

      fire[i] = accept[i] && (sync2_q[i] || REL_PULSE);

      // A new event reloads the stretcher, so back-to-back events extend the pulse.
      if (fire[i]) begin
        pulse_d[i] = 1'b1;
        st_d[i]    = StLoad;
      end else if (pulse_q[i]) begin
        if (st_q[i] == '0) begin
          pulse_d[i] = 1'b0;
        end else begin
          st_d[i] = st_q[i] - StOne;
        end
      end
    end
    any_d = |pulse_d;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      pulse_q <= '0;
      any_q   <= 1'b0;
      for (int unsigned i = 0; i < N_SW; i++) begin
        cnt_q[i] <= '0;
        st_q[i]  <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      any_q   <= any_d;
      for (int unsigned i = 0; i < N_SW; i++) begin
        cnt_q[i] <= cnt_d[i];
        st_q[i]  <= st_d[i];
      end
    end
  end

  assign sw_level  = level_q;
  assign sw_pulse  = pulse_q;
  assign any_pulse = any_q;

endmodule

// File: tb/tb_switch_pulse_gen.sv
// Randomized scoreboard bench for switch_pulse_gen. Two instances share stimulus:
// A = press-only, 1-cycle pulses; B = press+release, 3-cycle pulses.
module tb_switch_pulse_gen;

  localparam int unsigned NSw  = 3;
  localparam int unsigned Dc   = 4;
  localparam int          PlA  = 1;
  localparam int          PlB  = 3;
  localparam int          NCyc = 4000;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NSw-1:0] sw_raw;
  logic [NSw-1:0] lvl_a, pul_a, lvl_b, pul_b;
  logic           any_a, any_b;

  always #10 clk = ~clk;

  switch_pulse_gen #(
    .N_SW(NSw), .DEBOUNCE_CYC(Dc), .PULSE_LEN(PlA), .REL_PULSE(1'b0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw),
    .sw_level(lvl_a), .sw_pulse(pul_a), .any_pulse(any_a)
  );

  switch_pulse_gen #(
    .N_SW(NSw), .DEBOUNCE_CYC(Dc), .PULSE_LEN(PlB), .REL_PULSE(1'b1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw),
    .sw_level(lvl_b), .sw_pulse(pul_b), .any_pulse(any_b)
  );

  typedef struct packed {
    logic [NSw-1:0] lvl_a;
    logic [NSw-1:0] pul_a;
    logic           any_a;
    logic [NSw-1:0] lvl_b;
    logic [NSw-1:0] pul_b;
    logic           any_b;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   stim_done = 1'b0;

  // Reference model: raw sample seen two edges late, level flips once the last
  // Dc delayed samples all disagree with it; pulses last a fixed number of edges.
  bit m_p1[NSw];
  bit m_p2[NSw];
  bit m_lvl[NSw];
  int m_rem_a[NSw];
  int m_rem_b[NSw];
  bit m_win[NSw][$];

  task automatic model_step(input logic rst, input logic [NSw-1:0] raw, output exp_t e);
    bit s2, flip, all_diff;
    e = '0;
    for (int c = 0; c < NSw; c++) begin
      if (!rst) begin
        m_p1[c] = 1'b0;
        m_p2[c] = 1'b0;
        m_lvl[c] = 1'b0;
        m_rem_a[c] = 0;
        m_rem_b[c] = 0;
        m_win[c].delete();
      end else begin
        s2 = m_p2[c];
        m_p2[c] = m_p1[c];
        m_p1[c] = raw[c];
        m_win[c].push_back(s2);
        if (m_win[c].size() > Dc) void'(m_win[c].pop_front());
        all_diff = (m_win[c].size() == Dc);
        foreach (m_win[c][k]) if (m_win[c][k] == m_lvl[c]) all_diff = 1'b0;
        flip = all_diff;
        if (flip) m_lvl[c] = s2;
        if (flip && s2) m_rem_a[c] = PlA;
        else if (m_rem_a[c] > 0) m_rem_a[c]--;
        if (flip) m_rem_b[c] = PlB;
        else if (m_rem_b[c] > 0) m_rem_b[c]--;
      end
      e.lvl_a[c] = m_lvl[c];
      e.lvl_b[c] = m_lvl[c];
      e.pul_a[c] = (m_rem_a[c] > 0);
      e.pul_b[c] = (m_rem_b[c] > 0);
    end
    e.any_a = |e.pul_a;
    e.any_b = |e.pul_b;
  endtask

  task automatic check(input string name, input logic [NSw-1:0] act, input logic [NSw-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s at %0t: got %b want %b", name, $time, act, req);
    end
  endtask

  // Stimulus: model evaluated at each edge with the inputs the DUT samples.
  initial begin
    int   hold[NSw];
    exp_t e;
    rst_n  = 1'b0;
    sw_raw = 3'b111;
    for (int c = 0; c < NSw; c++) hold[c] = 12;
    for (int cyc = 0; cyc < NCyc; cyc++) begin
      @(posedge clk);
      model_step(rst_n, sw_raw, e);
      exp_q.push_back(e);
      #2;
      if (cyc < 2) rst_n = 1'b0;
      else if (!rst_n) rst_n = ($urandom_range(0, 1) == 0);
      else rst_n = ($urandom_range(0, 249) != 0);
      for (int c = 0; c < NSw; c++) begin
        if (hold[c] == 0) begin
          sw_raw[c] = ~sw_raw[c];
          hold[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3))
                                                : int'($urandom_range(4, 16));
        end else begin
          hold[c]--;
        end
      end
    end
    stim_done = 1'b1;
  end

  // Monitor: compare outputs on the falling edge against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("level_a", lvl_a, e.lvl_a);
        check("pulse_a", pul_a, e.pul_a);
        check("any_a", {2'b00, any_a}, {2'b00, e.any_a});
        check("level_b", lvl_b, e.lvl_b);
        check("pulse_b", pul_b, e.pul_b);
        check("any_b", {2'b00, any_b}, {2'b00, e.any_b});
      end
    end
  end

  initial begin
    wait (stim_done);
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
